// File: rtl/ext_bus_arbiter_pkg.sv
// Shared constants and helpers for the external bus sequencer/arbiter.
// FSM encoding, address-space selectors, default wait/timeout values.
package ext_bus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic RAM_SPACE = 1'b0;
    localparam logic IO_SPACE  = 1'b1;

    localparam int unsigned WAIT_W       = 32'd4;
    localparam int unsigned DEF_RAM_WAIT = 32'd1;
    localparam int unsigned DEF_IO_WAIT  = 32'd2;
    localparam int unsigned DEF_TIMEOUT  = 32'd64;

    // Wait-counter preload for the latched address space.
    function automatic logic [WAIT_W-1:0] wait_load(input logic space,
                                                   input logic [WAIT_W-1:0] ram_w,
                                                   input logic [WAIT_W-1:0] io_w);
        wait_load = (space == IO_SPACE) ? io_w : ram_w;
    endfunction

    // Strobe vector {we_ram, write_ext, read_ext}; a RAM read drives none.
    function automatic logic [2:0] decode_strobes(input logic space, input logic we);
        decode_strobes = (space == IO_SPACE) ? {1'b0, we, ~we} : {we, 1'b0, 1'b0};
    endfunction

endpackage

// File: rtl/ext_bus_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter: on a tie the master that did not win last is granted.
module rr_arbiter2
    import ext_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // One-hot grant; a single requester simply wins.
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ext_bus_arbiter.sv
// External memory/IO bus sequencer shared by two masters (m0 = CPU, m1 = loader/DMA).
// Optional IO abort timer is enabled by defining EXT_BUS_TIMEOUT_EN.
module ext_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int unsigned AW       = 18,
    parameter int unsigned DW       = 16,
    parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
    parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] dir_mem_ex,
    output logic          we_ram,
    output logic          write_ext,
    output logic          read_ext,
    output logic [DW-1:0] data_out,
    output logic          data_oe,
    input  logic [DW-1:0] data_in,
    input  logic          io_ready
);

    logic [1:0]        state_q, state_d;
    logic              gid_q, gid_d, last_q, last_d;
    logic              we_q, we_d, space_q, space_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]     dir_q, dir_d;
    logic [DW-1:0]     dout_q, dout_d, rdata_q, rdata_d;
    logic              data_oe_q, data_oe_d;
    logic [2:0]        strobe_q, strobe_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;

    logic [1:0]        gnt_s;
    logic              sel_s, sel_we_s, access_end_s, timeout_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_wdata_s;
    logic [2:0]        strobe_s;

    rr_arbiter2 u_arb (
        .req        ({m1_req, m0_req}),
        .en         (state_q == ST_IDLE),
        .last_grant (last_q),
        .gnt        (gnt_s)
    );

    assign sel_s        = gnt_s[1];
    assign sel_we_s     = sel_s ? m1_we    : m0_we;
    assign sel_addr_s   = sel_s ? m1_addr  : m0_addr;
    assign sel_wdata_s  = sel_s ? m1_wdata : m0_wdata;
    assign strobe_s     = decode_strobes(space_q, we_q);
    assign access_end_s = (cnt_q == {WAIT_W{1'b0}}) && ((space_q == RAM_SPACE) || io_ready);

`ifdef EXT_BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 32'd1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // IO abort timer: counts IO ACCESS cycles, cleared in SETUP.
    always_comb begin
        tmo_d     = tmo_q;
        timeout_s = (state_q == ST_ACCESS) && (space_q == IO_SPACE) &&
                    (tmo_q == TMO_W'(TIMEOUT - 32'd1));
        if (state_q == ST_SETUP) begin
            tmo_d = {TMO_W{1'b0}};
        end else if ((state_q == ST_ACCESS) && (space_q == IO_SPACE)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = tmo_q;
        end
    end

    // Abort timer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= {TMO_W{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT == 32'd0);
    assign timeout_s        = 1'b0;
`endif

    // Bus sequencer next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        last_d    = last_q;
        we_d      = we_q;
        space_d   = space_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        dout_d    = dout_q;
        rdata_d   = rdata_q;
        data_oe_d = 1'b0;
        strobe_d  = 3'b000;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_err_d  = 1'b0;
        m1_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_s != 2'b00) begin
                    state_d   = ST_SETUP;
                    gid_d     = sel_s;
                    last_d    = sel_s;
                    we_d      = sel_we_s;
                    space_d   = sel_addr_s[AW-1];
                    dir_d     = sel_addr_s;
                    dout_d    = sel_wdata_s;
                    data_oe_d = sel_we_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                cnt_d     = wait_load(space_q, WAIT_W'(RAM_WAIT), WAIT_W'(IO_WAIT));
                data_oe_d = we_q;
                strobe_d  = strobe_s;
            end
            ST_ACCESS: begin
                if (access_end_s) begin
                    state_d  = ST_DONE;
                    rdata_d  = we_q ? rdata_q : data_in;
                    m0_ack_d = ~gid_q;
                    m1_ack_d = gid_q;
                end else if (timeout_s) begin
                    state_d  = ST_DONE;
                    m0_ack_d = ~gid_q;
                    m1_ack_d = gid_q;
                    m0_err_d = ~gid_q;
                    m1_err_d = gid_q;
                end else begin
                    // Counter saturates at zero while an IO device holds off ready.
                    cnt_d     = (cnt_q == {WAIT_W{1'b0}}) ? cnt_q : (cnt_q - WAIT_W'(1));
                    data_oe_d = we_q;
                    strobe_d  = strobe_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves m1 as last winner so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gid_q     <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            space_q   <= RAM_SPACE;
            cnt_q     <= {WAIT_W{1'b0}};
            dir_q     <= {AW{1'b0}};
            dout_q    <= {DW{1'b0}};
            rdata_q   <= {DW{1'b0}};
            data_oe_q <= 1'b0;
            strobe_q  <= 3'b000;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gid_q     <= gid_d;
            last_q    <= last_d;
            we_q      <= we_d;
            space_q   <= space_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
            data_oe_q <= data_oe_d;
            strobe_q  <= strobe_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m0_err_q  <= m0_err_d;
            m1_err_q  <= m1_err_d;
        end
    end

    assign dir_mem_ex = dir_q;
    assign data_out   = dout_q;
    assign data_oe    = data_oe_q;
    assign rdata      = rdata_q;
    assign we_ram     = strobe_q[2];
    assign write_ext  = strobe_q[1];
    assign read_ext   = strobe_q[0];
    assign m0_ack     = m0_ack_q;
    assign m1_ack     = m1_ack_q;
    assign m0_err     = m0_err_q;
    assign m1_err     = m1_err_q;

endmodule
